round_robin_merger: RTL

ROUND_ROBIN_MERGER -- requirements
Module: round_robin_merger

---
 rtl/round_robin_merger.sv | 105 ++++++++++
 1 files changed

// File: rtl/round_robin_merger.sv
`default_nettype none
// ============================================================================
//  Module   : round_robin_merger
//  Purpose  : Merges four valid/ready sources onto one registered output
//             stream using a round-robin arbiter.  The beat on dout is tagged
//             with the index of the source it came from (dout_addr), so this
//             block is the inverse of a 1-to-4 address router.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in   rising-edge clock
//    reset               in   synchronous active-high reset
//    din0..din3          in   source data, DATA_WIDTH bits each
//    din_valid[3:0]      in   per-source beat present
//    din_ready[3:0]      out  per-source beat taken (at most one bit high)
//    dout                out  merged data (registered)
//    dout_addr[1:0]      out  source index of the beat on dout
//    dout_valid          out  dout/dout_addr hold a beat
//    dout_ready          in   sink accepts the beat
// ============================================================================
module round_robin_merger #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [3:0]            din_valid,
  output logic [3:0]            din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            dout_addr,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  // Last-grant pointer; the search starts one past it.
  logic [1:0]            lg;
  logic                  slot_free;
  logic                  grant_found;
  logic [1:0]            grant_idx;
  logic [1:0]            idx;
  logic                  take;
  logic [DATA_WIDTH-1:0] grant_data;

  // The output register can take a new beat when empty or being drained.
  assign slot_free = !dout_valid || dout_ready;

  // First valid source in order lg+1 .. lg+4; 2-bit wrap gives the modulo.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    idx         = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = lg + 2'(k);
      if (!grant_found && din_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Ready depends only on state, din_valid, dout_ready and reset; data
  // never reaches any output combinationally.
  always_comb begin
    din_ready = 4'b0000;
    if (grant_found && slot_free && !reset) begin
      din_ready[grant_idx] = 1'b1;
    end
  end

  assign take = |din_ready;

  always_comb begin
    grant_data = din0;
    case (grant_idx)
      2'd0:    grant_data = din0;
      2'd1:    grant_data = din1;
      2'd2:    grant_data = din2;
      2'd3:    grant_data = din3;
      default: grant_data = din0;
    endcase
  end

  // An input transfer overwrites the output register even when the current
  // beat leaves in the same cycle, which gives back-to-back throughput.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_addr  <= 2'd0;
      dout_valid <= 1'b0;
      lg         <= 2'd3;
    end else if (take) begin
      dout       <= grant_data;
      dout_addr  <= grant_idx;
      dout_valid <= 1'b1;
      lg         <= grant_idx;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
